ysyx_23060025_lsu_axi_bridge: RTL and testbench
===============================================

# ysyx_23060025_lsu_axi_bridge

Responder end of the LSU memory-request interface (`out_psel`/`out_pwrite`/`out_paddr`/`out_psize`/`out_pwdata`/`out_pwstrb` → `out_prdata`/`out_pvalid`). It accepts one request at a time from the LSU stage and converts it into a single AXI4-Lite-style transaction (AR/R or AW/W/B) on the memory bus. It then returns data or completion to the LSU and holds the response until the requester consumes it. It sits between `ysyx_23060025_lsu_stage` and the AXI arbiter/crossbar.

## Interface
- `DATA_LEN` — default 32 — data width.
- `ADDR_LEN` — default 32 — address width.
- `clock` in 1 — single clock; all logic on posedge.
- `rstn` in 1 — asynchronous, active-low reset.
- `in_psel` in 1 — request valid; held high by LSU until it consumes the response.
- `in_pwrite` in 1 — 1 = store, 0 = load.
- `in_paddr` in ADDR_LEN — byte address.
- `in_psize` in 3 — AXI size code (0 = 1 B, 1 = 2 B, 2 = 4 B).
- `in_pwdata` in DATA_LEN — store data, already lane-shifted.
- `in_pwstrb` in 4 — store byte strobe, already lane-shifted.
- `in_pack` in 1 — requester consumes the response this cycle; top level drives it with `lsu_to_wbu_valid_o & wbu_allowin_i`.
- `in_prdata` out DATA_LEN — load data, raw word from R channel.
- `in_pvalid` out 1 — response valid.
- `in_perr` out 1 — response carried a non-OKAY resp; valid only with `in_pvalid`.
- AR channel: `araddr` out ADDR_LEN, `arsize` out 3, `arvalid` out 1, `arready` in 1.
- R channel: `rdata` in DATA_LEN, `rresp` in 2, `rvalid` in 1, `rready` out 1.
- AW channel: `awaddr` out ADDR_LEN, `awsize` out 3, `awvalid` out 1, `awready` in 1.
- W channel: `wdata` out DATA_LEN, `wstrb` out 4, `wvalid` out 1, `wready` in 1.
- B channel: `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- **IDLE**
  - If `in_psel`, latch addr, size, wdata, wstrb and write into request registers.
  - Go to RD_A if `in_pwrite`=0, otherwise WR_AW.
- **RD_A**
  - `arvalid`=1 with the latched addr and size.
  - On `arready` go to RD_D.
- **RD_D**
  - `rready`=1.
  - On `rvalid`: latch `rdata` into `in_prdata`, set the err register to `rresp!=0`, go to RESP.
- **WR_AW**
  - `awvalid` and `wvalid` both assert on entry; each channel is tracked by its own done flag.
  - Each valid drops after its own handshake. AW first, W first, or both in the same cycle are all legal.
  - When both are done, go to WR_B.
- **WR_B**
  - `bready`=1.
  - On `bvalid`: set err to `bresp!=0`, go to RESP. `in_prdata` is left unchanged.
- **RESP**
  - `in_pvalid`=1; `in_prdata` and `in_perr` are held stable.
  - On `in_pack` go to IDLE.
  - Without `in_pack`, stay in RESP indefinitely and never re-issue. This covers a `in_psel` that is still high for the same request while the WBU stalls.
- After leaving RESP, a still-high `in_psel` in IDLE is treated as a new request.
- Address and size pass through unmodified; no alignment checking is done.
- The block never has more than one transaction outstanding.
- An `in_psel` drop in states other than IDLE/RESP is illegal and is ignored; the transaction completes.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from any AXI input to any AXI output.
- **Reset values:** state = IDLE; all valid/ready outputs 0; `in_pvalid` 0; `in_perr` 0; `in_prdata` 0; request registers 0.
- **Zero-wait load:**
  - Cycle 0: `in_psel` seen.
  - Cycle 1: `arvalid`; `arready` handshakes.
  - Cycle 2: `rready`, `rvalid` arrives.
  - Cycle 3: `in_pvalid`.
  - Load latency is 3 cycles plus slave waits.
- **Zero-wait store:** cycle 1 AW+W, cycle 2 B, cycle 3 `in_pvalid`.
- **Back-to-back:** with `in_pack` in cycle N, the next request is captured in cycle N+1 (IDLE) and its AXI valid asserts in cycle N+2.
- **Asynchronous reset mid-transaction:** all valids drop immediately and the transaction is abandoned. Slaves share the same reset.
- Valids, once asserted, hold with stable payload until their handshake (AXI rule).

## Structure
- Add to `ysyx_23060025_define.v`:
  - State encodings `LSU_BR_IDLE` … `LSU_BR_RESP`.
  - `AXI_RESP_OKAY` = 2'b00.
- Reuse the existing `AXI_ADDR_SIZE_*` constants.
- Single module; no sub-module. The AW/W done flags are two local registers.

## Test plan
- **Zero-wait load:** `in_psel`=1, write=0, addr 0x8000_0010, size 2; `arready`=`rvalid`=1; `rdata`=0x0302_0100 → `in_pvalid` in cycle 3, `in_prdata`=0x0302_0100, `in_perr`=0.
- **Delayed store, W before AW:** write, addr 0xA000_03F8, wdata 0x41, strb 4'b0001. `wready` at cycle 1, `awready` at cycle 4, `bvalid` at cycle 6 → `wvalid` low from cycle 2, `awvalid` low from cycle 5, `in_pvalid` at cycle 7.
- **Response stall:** load completes while `in_pack`=0 for 5 cycles and `in_psel` stays high → exactly one AR handshake, `in_pvalid` and `in_prdata` stable for all 5 cycles.
- **Back-to-back:** load then store with `in_pack` at the load's RESP cycle → the store's `awvalid` asserts 2 cycles later with the new addr and data.
- **Error responses:** `rresp`=2'b10 → `in_perr`=1 together with `in_pvalid`. `bresp`=2'b11 on a store → `in_perr`=1.
- **Reset mid-read:** `rstn`=0 asynchronously while `arvalid` is high → `arvalid`=0 before the next clock edge; after release the FSM is in IDLE, and a fresh `in_psel` issues a new AR.

Source files
------------

// File: rtl/ysyx_23060025_lsu_axi_bridge_pkg.sv
// rtl/ysyx_23060025_lsu_axi_bridge_pkg.sv - bridge state encodings and AXI response helpers
package ysyx_23060025_lsu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    LSU_BR_IDLE  = 3'd0,
    LSU_BR_RD_A  = 3'd1,
    LSU_BR_RD_D  = 3'd2,
    LSU_BR_WR_AW = 3'd3,
    LSU_BR_WR_B  = 3'd4,
    LSU_BR_RESP  = 3'd5
  } lsu_br_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060025_lsu_axi_bridge_if.sv
// rtl/ysyx_23060025_lsu_axi_bridge_if.sv - LSU request interface and AXI4-Lite memory bus interface
interface ysyx_23060025_lsu_axi_bridge_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic                in_psel;
  logic                in_pwrite;
  logic [ADDR_LEN-1:0] in_paddr;
  logic [2:0]          in_psize;
  logic [DATA_LEN-1:0] in_pwdata;
  logic [3:0]          in_pwstrb;
  logic                in_pack;
  logic [DATA_LEN-1:0] in_prdata;
  logic                in_pvalid;
  logic                in_perr;

  modport master (
    output in_psel, in_pwrite, in_paddr, in_psize, in_pwdata, in_pwstrb, in_pack,
    input  in_prdata, in_pvalid, in_perr
  );

  modport slave (
    input  in_psel, in_pwrite, in_paddr, in_psize, in_pwdata, in_pwstrb, in_pack,
    output in_prdata, in_pvalid, in_perr
  );
endinterface

interface ysyx_23060025_lsu_axi_bridge_axi_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0] araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [DATA_LEN-1:0] rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_LEN-1:0] awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_LEN-1:0] wdata;
  logic [3:0]          wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060025_lsu_axi_bridge.sv
// rtl/ysyx_23060025_lsu_axi_bridge.sv - turns one LSU request into one AXI4-Lite read or write
// Holds the response until the LSU consumes it; at most one transaction in flight.
module ysyx_23060025_lsu_axi_bridge
  import ysyx_23060025_lsu_axi_bridge_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                               clock,
  input  logic                               rstn,
  ysyx_23060025_lsu_axi_bridge_if.slave      lsu,
  ysyx_23060025_lsu_axi_bridge_axi_if.master axi
);

  lsu_br_state_e       state;
  lsu_br_state_e       state_next;

  logic [ADDR_LEN-1:0] req_addr;
  logic [2:0]          req_size;
  logic [DATA_LEN-1:0] req_wdata;
  logic [3:0]          req_wstrb;
  logic                req_write;
  logic                aw_done;
  logic                w_done;
  logic [DATA_LEN-1:0] prdata_q;
  logic                perr_q;

  logic                ar_valid;
  logic                aw_valid;
  logic                w_valid;
  logic                aw_fire;
  logic                w_fire;

  // Every AXI output comes from state or registers, never from an AXI input.
  assign ar_valid = (state == LSU_BR_RD_A);
  assign aw_valid = (state == LSU_BR_WR_AW) && !aw_done;
  assign w_valid  = (state == LSU_BR_WR_AW) && !w_done;
  assign aw_fire  = aw_valid && axi.awready;
  assign w_fire   = w_valid && axi.wready;

  assign axi.araddr  = req_addr;
  assign axi.arsize  = req_size;
  assign axi.arvalid = ar_valid;
  assign axi.rready  = (state == LSU_BR_RD_D);
  assign axi.awaddr  = req_addr;
  assign axi.awsize  = req_size;
  assign axi.awvalid = aw_valid;
  assign axi.wdata   = req_wdata;
  assign axi.wstrb   = req_wstrb;
  assign axi.wvalid  = w_valid;
  assign axi.bready  = (state == LSU_BR_WR_B);

  assign lsu.in_prdata = prdata_q;
  assign lsu.in_pvalid = (state == LSU_BR_RESP);
  assign lsu.in_perr   = perr_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state <= LSU_BR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LSU_BR_IDLE: begin
        if (lsu.in_psel) begin
          state_next = lsu.in_pwrite ? LSU_BR_WR_AW : LSU_BR_RD_A;
        end
      end
      LSU_BR_RD_A: begin
        if (axi.arready) begin
          state_next = LSU_BR_RD_D;
        end
      end
      LSU_BR_RD_D: begin
        if (axi.rvalid) begin
          state_next = LSU_BR_RESP;
        end
      end
      // AW and W complete independently, in either order or together.
      LSU_BR_WR_AW: begin
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          state_next = LSU_BR_WR_B;
        end
      end
      LSU_BR_WR_B: begin
        if (axi.bvalid) begin
          state_next = LSU_BR_RESP;
        end
      end
      LSU_BR_RESP: begin
        if (lsu.in_pack) begin
          state_next = LSU_BR_IDLE;
        end
      end
      default: state_next = LSU_BR_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      req_addr  <= '0;
      req_size  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_write <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      prdata_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      unique case (state)
        LSU_BR_IDLE: begin
          if (lsu.in_psel) begin
            req_addr  <= lsu.in_paddr;
            req_size  <= lsu.in_psize;
            req_wdata <= lsu.in_pwdata;
            req_wstrb <= lsu.in_pwstrb;
            req_write <= lsu.in_pwrite;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        LSU_BR_RD_D: begin
          if (axi.rvalid) begin
            prdata_q <= axi.rdata;
            perr_q   <= resp_is_err(axi.rresp);
          end
        end
        LSU_BR_WR_AW: begin
          if (aw_fire) begin
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            w_done <= 1'b1;
          end
        end
        // A store completion leaves the last load data in place.
        LSU_BR_WR_B: begin
          if (axi.bvalid) begin
            perr_q <= resp_is_err(axi.bresp);
          end
        end
        default: begin
        end
      endcase
    end
  end

  logic unused_req_write;
  assign unused_req_write = req_write;

endmodule

// File: tb/tb_ysyx_23060025_lsu_axi_bridge.sv
// tb/tb_ysyx_23060025_lsu_axi_bridge.sv - self-checking bench for the LSU-to-AXI bridge
module tb_ysyx_23060025_lsu_axi_bridge;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  always #5 clock = ~clock;

  ysyx_23060025_lsu_axi_bridge_if     #(.DATA_LEN(32), .ADDR_LEN(32)) lsu ();
  ysyx_23060025_lsu_axi_bridge_axi_if #(.DATA_LEN(32), .ADDR_LEN(32)) axi ();

  ysyx_23060025_lsu_axi_bridge #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock (clock),
    .rstn  (rstn),
    .lsu   (lsu),
    .axi   (axi)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          pack_delay;
    int          exp_lat;
    logic [31:0] exp_prdata;
    bit          exp_err;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_prdata = '0;

  // Slave configuration and observation
  int cfg_ar_wait, cfg_r_wait, cfg_aw_wait, cfg_w_wait, cfg_b_wait;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  int ar_cnt, aw_cnt, w_cnt, r_left, b_left;
  bit r_active, b_active, aw_got, w_got, b_started;
  bit ar_pend, aw_pend, w_pend;
  logic [34:0] prev_ar, prev_aw;
  logic [35:0] prev_w;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0, stab_err = 0;
  logic [31:0] hs_araddr, hs_awaddr, hs_wdata;
  logic [2:0]  hs_arsize, hs_awsize;
  logic [3:0]  hs_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Memory slave: programmable per-channel waits, payload capture at each handshake.
  always @(negedge clock) begin
    if (!rstn) begin
      axi.arready = 0; axi.awready = 0; axi.wready = 0;
      axi.rvalid = 0; axi.bvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.bresp = '0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_left = 0; b_left = 0;
      r_active = 0; b_active = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
    end else begin
      axi.rvalid = 0;
      axi.bvalid = 0;
      if (r_active) begin
        if (r_left > 0) r_left--;
        else if (axi.rready) begin
          axi.rvalid = 1; axi.rdata = cfg_rdata; axi.rresp = cfg_resp;
          r_active = 0; r_hs++;
        end
      end
      if (b_active) begin
        if (b_left > 0) b_left--;
        else if (axi.bready) begin
          axi.bvalid = 1; axi.bresp = cfg_resp;
          b_active = 0; b_hs++;
        end
      end
      if (axi.arvalid) begin
        if (ar_pend && {axi.araddr, axi.arsize} != prev_ar) stab_err++;
        prev_ar = {axi.araddr, axi.arsize};
        axi.arready = (ar_cnt >= cfg_ar_wait);
        ar_cnt++;
        if (axi.arready) begin
          ar_hs++; hs_araddr = axi.araddr; hs_arsize = axi.arsize;
          r_active = 1; r_left = cfg_r_wait; ar_pend = 0; ar_cnt = 0;
        end else ar_pend = 1;
      end else begin
        if (ar_pend) stab_err++;
        axi.arready = 0; ar_cnt = 0; ar_pend = 0;
      end
      if (axi.awvalid) begin
        if (aw_pend && {axi.awaddr, axi.awsize} != prev_aw) stab_err++;
        prev_aw = {axi.awaddr, axi.awsize};
        axi.awready = (aw_cnt >= cfg_aw_wait);
        aw_cnt++;
        if (axi.awready) begin
          aw_hs++; hs_awaddr = axi.awaddr; hs_awsize = axi.awsize;
          aw_got = 1; aw_pend = 0; aw_cnt = 0;
        end else aw_pend = 1;
      end else begin
        if (aw_pend) stab_err++;
        axi.awready = 0; aw_cnt = 0; aw_pend = 0;
      end
      if (axi.wvalid) begin
        if (w_pend && {axi.wdata, axi.wstrb} != prev_w) stab_err++;
        prev_w = {axi.wdata, axi.wstrb};
        axi.wready = (w_cnt >= cfg_w_wait);
        w_cnt++;
        if (axi.wready) begin
          w_hs++; hs_wdata = axi.wdata; hs_wstrb = axi.wstrb;
          w_got = 1; w_pend = 0; w_cnt = 0;
        end else w_pend = 1;
      end else begin
        if (w_pend) stab_err++;
        axi.wready = 0; w_cnt = 0; w_pend = 0;
      end
      if (aw_got && w_got && !b_started) begin
        b_started = 1; b_active = 1; b_left = cfg_b_wait;
      end
    end
  end

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] wd, input logic [3:0] st,
                              input int arw, input int rw, input int aww, input int ww, input int bw,
                              input logic [31:0] rd, input logic [1:0] rs, input int pd,
                              input int lat, input logic [31:0] epr, input bit eerr);
    vec_t v;
    v.write = w; v.addr = a; v.size = s; v.wdata = wd; v.wstrb = st;
    v.ar_w = arw; v.r_w = rw; v.aw_w = aww; v.w_w = ww; v.b_w = bw;
    v.rdata = rd; v.resp = rs; v.pack_delay = pd;
    v.exp_lat = lat; v.exp_prdata = epr; v.exp_err = eerr;
    return v;
  endfunction

  // Issues one request (psel stays high), waits for the response, stalls, then acks.
  task automatic run_txn(input vec_t v);
    int ar0, aw0, w0, r0, b0;
    int cyc, lat, first_valid, last_ar, last_aw, last_w;
    logic [31:0] hold;
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; r0 = r_hs; b0 = b_hs;
    cfg_ar_wait = v.ar_w; cfg_r_wait = v.r_w; cfg_aw_wait = v.aw_w;
    cfg_w_wait = v.w_w; cfg_b_wait = v.b_w; cfg_rdata = v.rdata; cfg_resp = v.resp;
    aw_got = 0; w_got = 0; b_started = 0;
    lsu.in_psel = 1; lsu.in_pwrite = v.write; lsu.in_paddr = v.addr; lsu.in_psize = v.size;
    lsu.in_pwdata = v.wdata; lsu.in_pwstrb = v.wstrb; lsu.in_pack = 0;
    cyc = 0; lat = -1; first_valid = -1; last_ar = -1; last_aw = -1; last_w = -1;
    while (lat < 0 && cyc < 200) begin
      step();
      cyc++;
      if (first_valid < 0 && (axi.arvalid || axi.awvalid)) first_valid = cyc;
      if (axi.arvalid) last_ar = cyc;
      if (axi.awvalid) last_aw = cyc;
      if (axi.wvalid) last_w = cyc;
      if (lsu.in_pvalid) lat = cyc;
    end
    chk("latency", lat, v.exp_lat);
    chk("first_valid_cycle", first_valid, 1);
    if (v.write) begin
      chk("awvalid_last_cycle", last_aw, 1 + v.aw_w);
      chk("wvalid_last_cycle", last_w, 1 + v.w_w);
    end else begin
      chk("arvalid_last_cycle", last_ar, 1 + v.ar_w);
    end
    chk("prdata", lsu.in_prdata, v.exp_prdata);
    chk("perr", lsu.in_perr, v.exp_err);
    hold = lsu.in_prdata;
    for (int i = 0; i < v.pack_delay; i++) begin
      step();
      chk("stall_pvalid", lsu.in_pvalid, 1);
      chk("stall_prdata", lsu.in_prdata, hold);
    end
    chk("ar_handshakes", ar_hs - ar0, v.write ? 0 : 1);
    chk("r_handshakes", r_hs - r0, v.write ? 0 : 1);
    chk("aw_handshakes", aw_hs - aw0, v.write ? 1 : 0);
    chk("w_handshakes", w_hs - w0, v.write ? 1 : 0);
    chk("b_handshakes", b_hs - b0, v.write ? 1 : 0);
    if (v.write) begin
      chk("awaddr", hs_awaddr, v.addr);
      chk("awsize", hs_awsize, v.size);
      chk("wdata", hs_wdata, v.wdata);
      chk("wstrb", hs_wstrb, v.wstrb);
    end else begin
      chk("araddr", hs_araddr, v.addr);
      chk("arsize", hs_arsize, v.size);
    end
    lsu.in_pack = 1;
    step();
    lsu.in_pack = 0;
    chk("pvalid_after_pack", lsu.in_pvalid, 0);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    lsu.in_psel = 0; lsu.in_pwrite = 0; lsu.in_paddr = '0; lsu.in_psize = '0;
    lsu.in_pwdata = '0; lsu.in_pwstrb = '0; lsu.in_pack = 0;
    cfg_ar_wait = 0; cfg_r_wait = 0; cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0;
    cfg_rdata = '0; cfg_resp = '0;

    tbl[0] = mk(0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'h0302_0100, 2'b00, 0, 3, 32'h0302_0100, 0);
    tbl[1] = mk(1, 32'hA000_03F8, 3'd0, 32'h0000_0041, 4'h1, 0, 0, 3, 0, 1, 32'h0,         2'b00, 0, 7, 32'h0302_0100, 0);
    tbl[2] = mk(0, 32'h0000_1002, 3'd1, 32'h0,         4'h0, 2, 1, 0, 0, 0, 32'hDEAD_BEEF, 2'b10, 5, 6, 32'hDEAD_BEEF, 1);
    tbl[3] = mk(1, 32'h1000_0000, 3'd0, 32'hAB00_0000, 4'h8, 0, 0, 0, 2, 0, 32'h0,         2'b11, 0, 5, 32'hDEAD_BEEF, 1);
    tbl[4] = mk(1, 32'h2000_0004, 3'd2, 32'h1122_3344, 4'hF, 0, 0, 1, 1, 2, 32'h0,         2'b00, 2, 6, 32'hDEAD_BEEF, 0);
    tbl[5] = mk(0, 32'h3000_0003, 3'd0, 32'h0,         4'h0, 0, 3, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 6, 32'h1234_5678, 0);

    step();
    step();
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_awvalid", axi.awvalid, 0);
    chk("reset_wvalid", axi.wvalid, 0);
    chk("reset_rready", axi.rready, 0);
    chk("reset_bready", axi.bready, 0);
    chk("reset_pvalid", lsu.in_pvalid, 0);
    chk("reset_perr", lsu.in_perr, 0);
    chk("reset_prdata", lsu.in_prdata, 0);
    rstn = 1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i]);
      model_prdata = tbl[i].exp_prdata;
    end
    lsu.in_psel = 0;
    step();

    // Asynchronous reset while AR is waiting on a slow slave
    cfg_ar_wait = 20;
    lsu.in_psel = 1; lsu.in_pwrite = 0; lsu.in_paddr = 32'h8000_0100; lsu.in_psize = 3'd2;
    step();
    chk("midrd_arvalid_before_reset", axi.arvalid, 1);
    #2 rstn = 0;
    #1;
    chk("midrd_arvalid_in_reset", axi.arvalid, 0);
    chk("midrd_pvalid_in_reset", lsu.in_pvalid, 0);
    chk("midrd_prdata_in_reset", lsu.in_prdata, 0);
    lsu.in_psel = 0;
    step();
    step();
    rstn = 1;
    model_prdata = '0;
    step();
    chk("midrd_idle_after_release", axi.arvalid, 0);
    run_txn(mk(0, 32'h8000_0100, 3'd2, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 0, 3, 32'hCAFE_F00D, 0));
    model_prdata = 32'hCAFE_F00D;

    // Randomized traffic against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      v.write = $urandom_range(0, 1);
      v.addr = $urandom;
      v.size = 3'($urandom_range(0, 2));
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.ar_w = $urandom_range(0, 3); v.r_w = $urandom_range(0, 3);
      v.aw_w = $urandom_range(0, 3); v.w_w = $urandom_range(0, 3); v.b_w = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.pack_delay = $urandom_range(0, 3);
      if (v.write) begin
        v.exp_lat = 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
        v.exp_prdata = model_prdata;
      end else begin
        v.exp_lat = 3 + v.ar_w + v.r_w;
        v.exp_prdata = v.rdata;
      end
      v.exp_err = (v.resp != 2'b00);
      run_txn(v);
      model_prdata = v.exp_prdata;
      if ($urandom_range(0, 2) == 0) begin
        lsu.in_psel = 0;
        for (int g = 0; g < 2; g++) begin
          step();
          chk("gap_pvalid", lsu.in_pvalid, 0);
          chk("gap_no_request", axi.arvalid | axi.awvalid, 0);
        end
      end
    end
    lsu.in_psel = 0;
    step();
    chk("axi_valid_stability", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
